// File: rtl/bus_enable_sync_rx.sv
// bus_enable_sync_rx: captures a source-held bus on the synchronized rising edge of bus_enable into a 2-entry valid/ready buffer.
// Optional macro BUS_SYNC_PARITY_EN adds even-parity screening (unsync_parity in, sticky parity_err out).
module bus_enable_sync_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_STAGES     = 2,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     unsync_bus,
    input  logic                      bus_enable,
`ifdef BUS_SYNC_PARITY_EN
    input  logic                      unsync_parity,
    output logic                      parity_err,
`endif
    output logic [DATA_WIDTH-1:0]     sync_bus,
    output logic                      sync_valid,
    input  logic                      sync_ready,
    output logic                      enable_pulse,
    output logic                      overrun,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
    input  logic                      clr_stats
);
    logic [NUM_STAGES-1:0] sync;
    logic                  prev, rise, par_ok, pop, push, drop;
    logic [DATA_WIDTH-1:0] mem [2];
    logic [DATA_WIDTH-1:0] last;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[NUM_STAGES-2:0], bus_enable};
            prev <= sync[NUM_STAGES-1];
        end
    end
`ifdef BUS_SYNC_PARITY_EN
    assign par_ok = (^unsync_bus) == unsync_parity;
`else
    assign par_ok = 1'b1;
`endif
    always_comb begin
        rise       = sync[NUM_STAGES-1] & ~prev;
        sync_valid = count != 2'd0;
        pop        = sync_valid & sync_ready;
        push       = rise & par_ok & ((count != 2'd2) | pop);
        drop       = rise & par_ok & (count == 2'd2) & ~pop;
        // An empty buffer keeps showing the word most recently at the head.
        sync_bus   = sync_valid ? mem[rd_ptr] : last;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0]       <= '0;
            mem[1]       <= '0;
            last         <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            enable_pulse <= 1'b0;
        end else begin
            if (push)
                mem[wr_ptr] <= unsync_bus;
            last         <= sync_bus;
            wr_ptr       <= wr_ptr ^ push;
            rd_ptr       <= rd_ptr ^ pop;
            count        <= count + {1'b0, push} - {1'b0, pop};
            enable_pulse <= rise;
        end
    end
    // A drop coinciding with clr_stats leaves a fresh count of one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            overrun  <= drop | (overrun & ~clr_stats);
            drop_cnt <= drop ? (clr_stats ? DROP_CNT_WIDTH'(1) :
                                (&drop_cnt ? drop_cnt : drop_cnt + DROP_CNT_WIDTH'(1)))
                             : (clr_stats ? '0 : drop_cnt);
        end
    end
`ifdef BUS_SYNC_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            parity_err <= 1'b0;
        else
            parity_err <= (rise & ~par_ok) | (parity_err & ~clr_stats);
    end
`endif
endmodule

// File: tb/tb_bus_enable_sync_rx.sv
// tb_bus_enable_sync_rx: directed and randomized checks of bus_enable_sync_rx against a queue-based model.
module tb_bus_enable_sync_rx;
    localparam int NS   = 2;
    localparam int DW   = 2;
    localparam int CMAX = (1 << DW) - 1;

    logic          clk = 0, rst = 0, bus_enable = 0, sync_ready = 0, clr_stats = 0;
    logic [7:0]    unsync_bus = 0;
    logic [7:0]    sync_bus;
    logic          sync_valid, enable_pulse, overrun;
    logic [DW-1:0] drop_cnt;
`ifdef BUS_SYNC_PARITY_EN
    logic          unsync_parity = 0, parity_err;
`endif

    int         cmp = 0, mis = 0, since = 0, m_cnt = 0;
    logic [7:0] q[$];
    logic [7:0] last = 0;
    bit         m_ovr = 0, m_perr = 0, m_cap = 0;

    bus_enable_sync_rx #(.DATA_WIDTH(8), .NUM_STAGES(NS), .DROP_CNT_WIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .unsync_bus(unsync_bus),
        .bus_enable(bus_enable),
`ifdef BUS_SYNC_PARITY_EN
        .unsync_parity(unsync_parity),
        .parity_err(parity_err),
`endif
        .sync_bus(sync_bus),
        .sync_valid(sync_valid),
        .sync_ready(sync_ready),
        .enable_pulse(enable_pulse),
        .overrun(overrun),
        .drop_cnt(drop_cnt),
        .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp++;
        assert (got === exp) else begin
            mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check();
        chk("sync_valid", {31'b0, sync_valid}, {31'b0, q.size() != 0});
        chk("sync_bus", {24'b0, sync_bus}, {24'b0, (q.size() != 0) ? q[0] : last});
        chk("enable_pulse", {31'b0, enable_pulse}, {31'b0, m_cap});
        chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
        chk("drop_cnt", {30'b0, drop_cnt}, m_cnt);
`ifdef BUS_SYNC_PARITY_EN
        chk("parity_err", {31'b0, parity_err}, {31'b0, m_perr});
`endif
    endtask

    // One clock: the capture lands on the (NS+1)th edge that sees bus_enable high.
    task automatic tick(input bit r, input bit c);
        bit pop, bad;
        sync_ready = r;
        clr_stats  = c;
        pop   = (q.size() != 0) && r;
        since = bus_enable ? since + 1 : 0;
        bad   = 0;
`ifdef BUS_SYNC_PARITY_EN
        bad = (^unsync_bus) != unsync_parity;
`endif
        @(posedge clk);
        m_cap = since == NS + 1;
        if (c) begin
            m_ovr  = 0;
            m_cnt  = 0;
            m_perr = 0;
        end
        if (pop) last = q.pop_front();
        if (m_cap && bad) m_perr = 1;
        else if (m_cap && q.size() < 2) q.push_back(unsync_bus);
        else if (m_cap) begin
            m_ovr = 1;
            m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        end
        #1;
        check();
    endtask

    task automatic send(input logic [7:0] w, input bit rc, input bit cc, input bit rnd, input bit badpar);
        unsync_bus = w;
`ifdef BUS_SYNC_PARITY_EN
        unsync_parity = (^w) ^ badpar;
`endif
        bus_enable = 1;
        for (int i = 1; i <= NS + 1; i++)
            tick(rnd ? 1'($urandom_range(0, 1)) : (i == NS + 1 ? rc : 1'b0),
                 rnd ? ($urandom_range(0, 7) == 0) : (i == NS + 1 ? cc : 1'b0));
        bus_enable = 0;
        for (int i = 0; i < NS + 2; i++)
            tick(rnd ? 1'($urandom_range(0, 1)) : 1'b0, rnd ? ($urandom_range(0, 7) == 0) : 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        check();
        @(negedge clk);
        rst = 1;

        send(8'hA5, 0, 0, 0, 0);
        chk("single_bus", {24'b0, sync_bus}, 32'hA5);
        repeat (2) tick(1, 0);

        send(8'h11, 0, 0, 0, 0);
        send(8'h22, 0, 0, 0, 0);
        send(8'h33, 0, 0, 0, 0);
        chk("b2b_drop_cnt", {30'b0, drop_cnt}, 1);
        repeat (3) tick(1, 0);

        send(8'h55, 0, 0, 0, 0);
        send(8'h66, 0, 0, 0, 0);
        send(8'h44, 1, 0, 0, 0);
        repeat (3) tick(1, 0);

        send(8'h01, 0, 0, 0, 0);
        send(8'h02, 0, 0, 0, 0);
        repeat (5) send(8'($urandom), 0, 0, 0, 0);
        chk("sat_drop_cnt", {30'b0, drop_cnt}, CMAX);
        tick(0, 1);
        send(8'h09, 0, 1, 0, 0);
        chk("clr_drop_cnt", {30'b0, drop_cnt}, 1);
        repeat (3) tick(1, 0);

        send(8'h21, 0, 0, 0, 0);
        send(8'h42, 0, 0, 0, 0);
        unsync_bus = 8'h77;
`ifdef BUS_SYNC_PARITY_EN
        unsync_parity = ^unsync_bus;
`endif
        bus_enable = 1;
        tick(0, 0);
        #2;
        rst = 0;
        q.delete();
        last  = 0;
        m_ovr = 0;
        m_cnt = 0;
        m_perr = 0;
        m_cap = 0;
        since = 0;
        #1;
        check();
        @(negedge clk);
        rst = 1;
        repeat (NS + 3) tick(0, 0);
        bus_enable = 0;
        repeat (NS + 2) tick(0, 0);
        chk("rst_recap_bus", {24'b0, sync_bus}, 32'h77);
        repeat (2) tick(1, 0);

`ifdef BUS_SYNC_PARITY_EN
        send(8'h03, 0, 0, 0, 1);
        chk("par_bad_err", {31'b0, parity_err}, 1);
        send(8'h03, 0, 0, 0, 0);
        chk("par_ok_bus", {24'b0, sync_bus}, 32'h03);
        repeat (2) tick(1, 0);
`endif

        repeat (40) send(8'($urandom), 0, 0, 1, $urandom_range(0, 3) == 0);
        repeat (4) tick(1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule

// File: doc/bus_enable_sync_rx.md
Name: bus_enable_sync_rx

Overview:
- Destination-domain receiver for a multi-bit bus that crosses from another clock domain under a qualifying enable.
- Synchronizes the source-held bus_enable through a NUM_STAGES flop chain, detects its rising edge and captures the stable unsync_bus on that edge.
- Queues captured words in a 2-entry buffer and presents them on a valid/ready interface.
- Sits downstream of the multi-flop synchronizer stage and feeds register-file or ALU consumers in the clk domain.

Parameters:
- DATA_WIDTH, 8, width of the crossing bus.
- NUM_STAGES, 2, synchronizer depth for bus_enable; legal values are 2 or more.
- DROP_CNT_WIDTH, 8, width of the saturating dropped-word counter.

Ports:
- clk  input  1  destination-domain clock.
- rst  input  1  reset, asynchronous, active-low.
- unsync_bus  input  DATA_WIDTH  source-domain data, held stable while bus_enable is high.
- bus_enable  input  1  source-domain qualifier; a level that stays high at least NUM_STAGES+1 clk cycles and stays low at least NUM_STAGES+1 cycles between words.
- sync_bus  output  DATA_WIDTH  head-of-buffer data.
- sync_valid  output  1  buffer is non-empty.
- sync_ready  input  1  consumer accepts the head word.
- enable_pulse  output  1  one-cycle strobe marking each capture attempt.
- overrun  output  1  sticky flag; a word was dropped because the buffer was full.
- drop_cnt  output  DROP_CNT_WIDTH  saturating count of dropped words.
- clr_stats  input  1  synchronous clear of overrun and drop_cnt.

Behaviour:
- Reset (rst low, asynchronous):
  - all sync flops, the edge-detect flop, buffer, pointers and occupancy go to 0.
  - sync_bus = 0, sync_valid = 0, enable_pulse = 0, overrun = 0, drop_cnt = 0.
  - Reset mid-transfer discards buffered words. After release, a bus_enable that is already high is seen as a new rising edge once it has propagated through the chain.
- Synchronizer:
  - sync[0] <= bus_enable; sync[i] <= sync[i-1] for i = 1 .. NUM_STAGES-1; prev <= sync[NUM_STAGES-1].
  - edge = sync[NUM_STAGES-1] & ~prev.
- Latency:
  - If bus_enable rises before clk edge 1, sync[NUM_STAGES-1] goes high after edge NUM_STAGES.
  - At edge NUM_STAGES+1, enable_pulse is registered high for exactly one cycle and unsync_bus is sampled.
  - With an empty buffer and sync_ready low, sync_valid is high after edge NUM_STAGES+1.
- Buffer:
  - 2 entries, circular, with 1-bit write and read pointers and a 2-bit occupancy count.
  - sync_bus = entry[rd_ptr]. When the buffer is empty, sync_bus holds its last value (0 after reset).
  - Pop on sync_valid & sync_ready.
  - Push on edge, when occupancy < 2 or a pop happens in the same cycle.
  - Full, with push and pop in the same cycle: the word is accepted, occupancy stays at 2, nothing is dropped.
  - Full, with edge and no pop: the word is dropped. overrun <= 1 and drop_cnt increments, saturating at all-ones.
  - enable_pulse is asserted whether or not the word is accepted.
- Stats:
  - clr_stats clears overrun and drop_cnt.
  - If a drop happens in the same cycle as clr_stats, the drop wins: overrun = 1, drop_cnt = 1.
- A bus_enable falling edge produces no action.
- bus_enable pulses shorter than the minimum width may be missed; detecting them is out of scope.

Optional Feature:
- Macro: BUS_SYNC_PARITY_EN.
- With the macro defined:
  - Added input unsync_parity (1 bit, even parity over unsync_bus, same timing as unsync_bus).
  - Added output parity_err (1 bit, sticky, reset 0, cleared by clr_stats).
  - On edge, if ^unsync_bus != unsync_parity: the word is not pushed, parity_err <= 1, and drop_cnt and overrun are unaffected. enable_pulse still fires.
- Without the macro: neither port exists and every edge attempts a push.

Test Plan:
- Single transfer: NUM_STAGES=2, unsync_bus=8'hA5, bus_enable raised before edge 1, sync_ready=0 -> enable_pulse high only in the cycle after edge 3, sync_valid=1, sync_bus=8'hA5 after edge 3.
- Back-to-back: words 8'h11, 8'h22, 8'h33 sent with sync_ready=0 -> buffer holds 11 and 22, word 33 dropped, overrun=1, drop_cnt=1. Then sync_ready=1 -> sync_bus shows 11 then 22, after which sync_valid=0.
- Full buffer with a simultaneous pop: occupancy 2, sync_ready=1 in the edge cycle with word 8'h44 -> no drop, drop_cnt unchanged, order is head, second word, 44.
- Saturation and clear: DROP_CNT_WIDTH=2, force 5 drops -> drop_cnt=3. Pulse clr_stats -> 0. clr_stats coincident with a drop -> overrun=1, drop_cnt=1.
- Reset mid-operation: assert rst with 2 words buffered and bus_enable high -> all outputs 0 immediately. Release with bus_enable still high -> exactly one capture after NUM_STAGES+1 edges.
- BUS_SYNC_PARITY_EN: send 8'h03 with unsync_parity=1 -> not pushed, parity_err=1, drop_cnt=0. Send 8'h03 with unsync_parity=0 -> pushed, sync_bus=8'h03.
